// File: rtl/onehot_decoder_seq.sv
// onehot_decoder_seq: sequenced 3-to-8 one-hot decoder.
// Incoming 3-bit codes queue in a small FIFO. Each code is replayed as a
// one-hot word on y for HOLD enabled cycles. Back-to-back words have no gap
// when another code is already queued at the last hold cycle.
module onehot_decoder_seq #(
   parameter int DEPTH = 4,   // code FIFO depth, power of 2, >= 2
   parameter int HOLD  = 3    // enabled cycles per word, 1..255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] in,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       enable,
   output logic [7:0] y,
   output logic       y_valid,
   output logic       busy
);

   localparam int         AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [7:0] HOLD_M1  = 8'(HOLD - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_HOLD = 1'b1;

   logic [DEPTH-1:0][2:0] mem;
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [AW:0]           count;
   logic [0:0]            state;
   logic [7:0]            cnt;

   logic       full, empty, push, pop;
   logic [2:0] head;

   // in_ready looks only at occupancy, so a full FIFO refuses a push even
   // when the sequencer pops in the same cycle.
   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign in_ready = !full;
   assign push     = in_valid && !full;
   assign head     = mem[rd_ptr];
   assign busy     = y_valid || !empty;

   // Pop when idle, or at the last hold cycle; a paused sequencer never pops.
   assign pop = enable && !empty && ((state == S_IDLE) || (cnt == 8'd0));

   // FIFO storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in;
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Output sequencer: load a word on pop, count it down while enabled,
   // drop to idle when the last cycle passes with nothing queued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= 8'd0;
         y       <= 8'h00;
         y_valid <= 1'b0;
      end else if (pop) begin
         y       <= 8'd1 << head;
         y_valid <= 1'b1;
         cnt     <= HOLD_M1;
         state   <= S_HOLD;
      end else if ((state == S_HOLD) && enable) begin
         if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
         end else begin
            y       <= 8'h00;
            y_valid <= 1'b0;
            state   <= S_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Bench for onehot_decoder_seq: directed cycle table on a HOLD=3 instance,
// hand-written async-reset sequence, and an in-order 0..7 scoreboard run
// on both a HOLD=3 and a HOLD=1 instance.
module tb_onehot_decoder_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] in0 = '0, in1 = '0;
   logic       iv0 = 1'b0, iv1 = 1'b0;
   logic       en0 = 1'b0, en1 = 1'b0;
   logic       rdy0, rdy1, yv0, yv1, busy0, busy1;
   logic [7:0] y0, y1;

   int tests = 0;
   int fails = 0;

   onehot_decoder_seq #(.DEPTH(4), .HOLD(3)) u0 (
      .clk(clk), .rst(rst), .in(in0), .in_valid(iv0), .in_ready(rdy0),
      .enable(en0), .y(y0), .y_valid(yv0), .busy(busy0));

   onehot_decoder_seq #(.DEPTH(4), .HOLD(1)) u1 (
      .clk(clk), .rst(rst), .in(in1), .in_valid(iv1), .in_ready(rdy1),
      .enable(en1), .y(y1), .y_valid(yv1), .busy(busy1));

   always #5 clk = ~clk;

   typedef struct {
      logic       vin;
      logic [2:0] din;
      logic       en;
      logic [7:0] y;
      logic       yv;
      logic       rdy;
      logic       busy;
      logic [7:0] cnt;
   } vec_t;

   vec_t vq[$];

   function automatic void add(input logic vin, input logic [2:0] din, input logic en,
                               input logic [7:0] y, input logic yv, input logic rdy,
                               input logic busy, input logic [7:0] cnt);
      vq.push_back('{vin, din, en, y, yv, rdy, busy, cnt});
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // In-order 0..7 run with scoreboard, one-hot check and hold-length check.
   task automatic exh(input int s, input int hold);
      int pi, rc, run, cyc, code;
      int q[$];
      logic [7:0] prev, ym;
      logic yvm, rdym, acc;
      pi = 0; rc = 0; run = 0; cyc = 0; prev = 8'h00;
      while (cyc < 200 && !(pi == 8 && rc == 8 && !(s != 0 ? busy1 : busy0))) begin
         rdym = (s != 0) ? rdy1 : rdy0;
         if (s == 0) begin iv0 = (pi < 8); in0 = 3'(pi); en0 = 1'b1; end
         else        begin iv1 = (pi < 8); in1 = 3'(pi); en1 = 1'b1; end
         acc = (pi < 8) && rdym;
         @(posedge clk); #1;
         cyc++;
         if (acc) begin q.push_back(pi); pi++; end
         ym  = (s != 0) ? y1 : y0;
         yvm = (s != 0) ? yv1 : yv0;
         chk($sformatf("onehot h%0d", hold), $countones(ym), 32'(yvm));
         if (yvm && ym != prev) begin
            if (prev != 8'h00) chk($sformatf("hold len h%0d", hold), run, hold);
            if (q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected word h%0d: got %h want none", hold, ym);
            end else begin
               code = q.pop_front();
               chk($sformatf("order h%0d", hold), ym, 8'd1 << code);
               rc++;
            end
            run = 1;
         end else if (yvm) begin
            run++;
         end else begin
            if (prev != 8'h00) chk($sformatf("hold len h%0d", hold), run, hold);
            run = 0;
         end
         prev = ym;
      end
      iv0 = 1'b0; iv1 = 1'b0; en0 = 1'b0; en1 = 1'b0;
      chk($sformatf("exh words h%0d", hold), rc, 8);
      chk($sformatf("exh timeout h%0d", hold), 32'(cyc < 200), 1);
   endtask

   initial begin
      // single code 5
      add(1,5,1,8'h00,0,1,1,0); add(0,0,1,8'h20,1,1,1,2); add(0,0,1,8'h20,1,1,1,1);
      add(0,0,1,8'h20,1,1,1,0); add(0,0,1,8'h00,0,1,0,0);
      // burst 0,1,7,4,2
      add(1,0,1,8'h00,0,1,1,0); add(1,1,1,8'h01,1,1,1,2); add(1,7,1,8'h01,1,1,1,1);
      add(1,4,1,8'h01,1,1,1,0); add(1,2,1,8'h02,1,1,1,2); add(0,0,1,8'h02,1,1,1,1);
      add(0,0,1,8'h02,1,1,1,0); add(0,0,1,8'h80,1,1,1,2); add(0,0,1,8'h80,1,1,1,1);
      add(0,0,1,8'h80,1,1,1,0); add(0,0,1,8'h10,1,1,1,2); add(0,0,1,8'h10,1,1,1,1);
      add(0,0,1,8'h10,1,1,1,0); add(0,0,1,8'h04,1,1,1,2); add(0,0,1,8'h04,1,1,1,1);
      add(0,0,1,8'h04,1,1,1,0); add(0,0,1,8'h00,0,1,0,0);
      // pause during 2nd cycle of 8'h08
      add(1,3,1,8'h00,0,1,1,0); add(1,6,1,8'h08,1,1,1,2); add(0,0,1,8'h08,1,1,1,1);
      add(0,0,0,8'h08,1,1,1,1); add(0,0,0,8'h08,1,1,1,1); add(0,0,1,8'h08,1,1,1,0);
      add(0,0,1,8'h40,1,1,1,2); add(0,0,1,8'h40,1,1,1,1); add(0,0,1,8'h40,1,1,1,0);
      add(0,0,1,8'h00,0,1,0,0);
      // enable gating in idle
      add(1,6,0,8'h00,0,1,1,0); add(1,1,0,8'h00,0,1,1,0); add(0,0,0,8'h00,0,1,1,0);
      add(0,0,1,8'h40,1,1,1,2); add(0,0,1,8'h40,1,1,1,1); add(0,0,1,8'h40,1,1,1,0);
      add(0,0,1,8'h02,1,1,1,2); add(0,0,1,8'h02,1,1,1,1); add(0,0,1,8'h02,1,1,1,0);
      add(0,0,1,8'h00,0,1,0,0);
      // fill to full, blocked pushes (incl. with pop) then retried
      add(1,1,0,8'h00,0,1,1,0); add(1,2,0,8'h00,0,1,1,0); add(1,3,0,8'h00,0,1,1,0);
      add(1,4,0,8'h00,0,0,1,0); add(1,5,0,8'h00,0,0,1,0); add(1,5,1,8'h02,1,1,1,2);
      add(1,5,1,8'h02,1,0,1,1); add(0,0,1,8'h02,1,0,1,0); add(0,0,1,8'h04,1,1,1,2);
      add(0,0,1,8'h04,1,1,1,1); add(0,0,1,8'h04,1,1,1,0); add(0,0,1,8'h08,1,1,1,2);
      add(0,0,1,8'h08,1,1,1,1); add(0,0,1,8'h08,1,1,1,0); add(0,0,1,8'h10,1,1,1,2);
      add(0,0,1,8'h10,1,1,1,1); add(0,0,1,8'h10,1,1,1,0); add(0,0,1,8'h20,1,1,1,2);
      add(0,0,1,8'h20,1,1,1,1); add(0,0,1,8'h20,1,1,1,0); add(0,0,1,8'h00,0,1,0,0);
      // push on last hold cycle of an empty FIFO: one idle cycle, then load
      add(1,2,1,8'h00,0,1,1,0); add(0,0,1,8'h04,1,1,1,2); add(0,0,1,8'h04,1,1,1,1);
      add(0,0,1,8'h04,1,1,1,0); add(1,7,1,8'h00,0,1,1,0); add(0,0,1,8'h80,1,1,1,2);
      add(0,0,1,8'h80,1,1,1,1); add(0,0,1,8'h80,1,1,1,0); add(0,0,1,8'h00,0,1,0,0);

      // reset state while rst is held
      #3;
      chk("rst y", {y0, yv0, rdy0, busy0}, {8'h00, 1'b0, 1'b1, 1'b0});
      chk("rst y h1", {y1, yv1, rdy1, busy1}, {8'h00, 1'b0, 1'b1, 1'b0});
      chk("rst cnt", u0.cnt, 8'd0);
      #9 rst = 1'b0;

      // directed table
      foreach (vq[i]) begin
         iv0 = vq[i].vin; in0 = vq[i].din; en0 = vq[i].en;
         @(posedge clk); #1;
         tests++;
         if ({y0, yv0, rdy0, busy0, u0.cnt} !== {vq[i].y, vq[i].yv, vq[i].rdy, vq[i].busy, vq[i].cnt}) begin
            fails++;
            $display("FAIL vec[%0d]: got y=%h yv=%b rdy=%b busy=%b cnt=%0d want y=%h yv=%b rdy=%b busy=%b cnt=%0d",
                     i, y0, yv0, rdy0, busy0, u0.cnt,
                     vq[i].y, vq[i].yv, vq[i].rdy, vq[i].busy, vq[i].cnt);
         end
      end
      iv0 = 1'b0; en0 = 1'b0;

      // async reset mid-hold with 3 codes queued
      for (int c = 1; c <= 4; c++) begin
         iv0 = 1'b1; in0 = 3'(c);
         @(posedge clk); #1;
      end
      iv0 = 1'b0; en0 = 1'b1;
      @(posedge clk); #1;
      chk("pre-rst y", y0, 8'h02);
      chk("pre-rst rdy", rdy0, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("async rst outs", {y0, yv0, rdy0, busy0}, {8'h00, 1'b0, 1'b1, 1'b0});
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         chk("no stale", {y0, yv0, busy0}, {8'h00, 1'b0, 1'b0});
      end
      iv0 = 1'b1; in0 = 3'd6;
      @(posedge clk); #1;
      iv0 = 1'b0;
      @(posedge clk); #1;
      chk("post-rst word", y0, 8'h40);
      repeat (3) @(posedge clk);
      #1;
      chk("post-rst idle", {y0, yv0}, {8'h00, 1'b0});
      en0 = 1'b0;

      // in-order 0..7 on both HOLD settings
      exh(0, 3);
      exh(1, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
